// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: opcodes, FSM states
// and the default operand width (one iteration per operand bit).
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } muldiv_state_t;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_ITERS = MD_WIDTH;

    function automatic logic isDivOp(input muldiv_op_t o);
        return o[1];
    endfunction

    function automatic logic isSignedOp(input muldiv_op_t o);
        return ~o[0];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One combinational step of shift-add multiply or restoring divide on the
// 2*WIDTH accumulator ({upper, multiplier} or {remainder, quotient}).
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic                 isDiv_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   shifted;

    // The remainder bit shifted out on the left is kept as a 33rd trial bit
    // so large unsigned divisors compare correctly.
    always_comb begin
        sum     = '0;
        trial   = '0;
        shifted = '0;
        acc_o   = acc_i;
        if (isDiv_i) begin
            shifted = {acc_i[2*WIDTH-2:0], 1'b0};
            trial   = {acc_i[2*WIDTH-1], shifted[2*WIDTH-1:WIDTH]} - {1'b0, opnd_i};
            if (!trial[WIDTH]) begin
                acc_o = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
            end else begin
                acc_o = shifted;
            end
        end else begin
            sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle mult/multu/div/divu with architectural HI/LO registers.
// Operands are run as magnitudes; signs are applied once in FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               wr_hi,
    input  logic               wr_lo,
    input  logic [WIDTH-1:0]   wdata,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    muldiv_state_t        state_q, state_d;
    muldiv_op_t           op_q, op_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 resSign_q, resSign_d;
    logic                 divSign_q, divSign_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, accStep;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

    muldiv_op_t           opIn;
    logic                 signedIn;
    logic [WIDTH-1:0]     absA, absB;
    logic                 lastIter;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     quot, rem;

    assign opIn     = muldiv_op_t'(op);
    assign signedIn = isSignedOp(opIn);
    assign absA     = (signedIn && a[WIDTH-1]) ? -a : a;
    assign absB     = (signedIn && b[WIDTH-1]) ? -b : b;
    assign lastIter = (cnt_q == CW'(WIDTH - 1));
    assign product  = resSign_q ? -acc_q : acc_q;
    assign quot     = acc_q[WIDTH-1:0];
    assign rem      = acc_q[2*WIDTH-1:WIDTH];

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .isDiv_i (isDivOp(op_q)),
        .acc_i   (acc_q),
        .opnd_i  (opnd_q),
        .acc_o   (accStep)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (lastIter) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // A zero divisor runs through the restoring loop unchanged; only the
    // signed quotient needs forcing, since negating all-ones would give 1.
    always_comb begin
        op_d      = op_q;
        cnt_d     = cnt_q;
        resSign_d = resSign_q;
        divSign_d = divSign_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (wr_hi) hi_d = wdata;
                if (wr_lo) lo_d = wdata;
                if (start) begin
                    op_d      = opIn;
                    cnt_d     = '0;
                    resSign_d = signedIn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    divSign_d = signedIn & a[WIDTH-1];
                    if (isDivOp(opIn)) begin
                        acc_d  = {{WIDTH{1'b0}}, absA};
                        opnd_d = absB;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, absB};
                        opnd_d = absA;
                    end
                end
            end
            RUN: begin
                acc_d = accStep;
                cnt_d = cnt_q + 1'b1;
            end
            FIX: begin
                if (isDivOp(op_q)) begin
                    if (isSignedOp(op_q) && (opnd_q == '0)) lo_d = '1;
                    else                                    lo_d = resSign_q ? -quot : quot;
                    hi_d = divSign_q ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = product;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= OP_MULT;
            cnt_q     <= '0;
            resSign_q <= 1'b0;
            divSign_q <= 1'b0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            resSign_q <= resSign_d;
            divSign_q <= divSign_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus queues expected HI/LO, a
// monitor pops and compares whenever done pulses.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   opIn;
    logic [31:0]  aIn, bIn;
    logic         wrHi, wrLo;
    logic [31:0]  wdata;
    logic         busy, done;
    logic [31:0]  hi, lo;

    int           errors = 0;
    int           checks = 0;
    logic [63:0]  expQ[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (opIn),
        .a     (aIn),
        .b     (bIn),
        .wr_hi (wrHi),
        .wr_lo (wrLo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (!reset && done) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDone: got done=1, expected done=0");
            end else begin
                exp = expQ.pop_front();
                checkOutput("resultHi", hi, exp[63:32]);
                checkOutput("resultLo", lo, exp[31:0]);
            end
        end
    end

    // Launch one op and watch its timing; optional disturbances while busy.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expHi, input logic [31:0] expLo,
                                 input int glitchCycle, input int wrLoCycle,
                                 input bit wrHiAtStart, input logic [31:0] priorLo);
        int doneCycle;
        int busyLow;
        @(negedge clk);
        start = 1'b1;
        opIn  = op;
        aIn   = a;
        bIn   = b;
        if (wrHiAtStart) begin
            wrHi  = 1'b1;
            wdata = 32'hCAFE0001;
        end
        expQ.push_back({expHi, expLo});
        doneCycle = 0;
        busyLow   = 0;
        for (int n = 1; n <= 40 && doneCycle == 0; n++) begin
            @(negedge clk);
            start = 1'b0;
            wrHi  = 1'b0;
            wrLo  = 1'b0;
            aIn   = $urandom;
            bIn   = $urandom;
            opIn  = 2'($urandom);
            if (n <= 33 && !busy) busyLow++;
            if (n == 1 && wrHiAtStart) checkOutput("mthiWithStart", hi, 32'hCAFE0001);
            if (wrLoCycle != 0 && n == wrLoCycle + 1) checkOutput("mtloIgnoredBusy", lo, priorLo);
            if (done) doneCycle = n;
            if (n == glitchCycle) start = 1'b1;
            if (n == wrLoCycle) begin
                wrLo  = 1'b1;
                wdata = 32'hDEADBEEF;
            end
        end
        checkOutput("doneCycle", 32'(doneCycle), 32'd34);
        checkOutput("busyDuringRun", 32'(busyLow), 32'd0);
        @(negedge clk);
        checkOutput("busyAfterDone", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int doneSeen;
        reset = 1'b1;
        start = 1'b0;
        opIn  = 2'b00;
        aIn   = '0;
        bIn   = '0;
        wrHi  = 1'b0;
        wrLo  = 1'b0;
        wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("resetBusy", {31'b0, busy}, 32'd0);
        checkOutput("resetDone", {31'b0, done}, 32'd0);
        checkOutput("resetHi", hi, 32'd0);
        checkOutput("resetLo", lo, 32'd0);

        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0, 1'b0, 32'h0);
        applyStimulus(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0, 0, 1'b0, 32'h0);
        applyStimulus(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 0, 1'b0, 32'h0);
        applyStimulus(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 1'b0, 32'h0);
        applyStimulus(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 0, 1'b0, 32'h0);
        applyStimulus(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0, 1'b0, 32'h0);
        applyStimulus(OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 0, 0, 1'b0, 32'h0);
        applyStimulus(OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 0, 0, 1'b0, 32'h0);
        applyStimulus(OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 0, 0, 1'b0, 32'h0);
        applyStimulus(OP_MULTU, 32'd6,        32'd7,        32'h00000000, 32'd42,       10, 12, 1'b0, 32'hFFFFFFFF);
        applyStimulus(OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 1'b1, 32'h0);

        // Abort a divide with reset: no done, HI/LO cleared, idle next cycle.
        @(negedge clk);
        start = 1'b1;
        opIn  = OP_DIV;
        aIn   = 32'd100;
        bIn   = 32'd7;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 20) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abortBusy", {31'b0, busy}, 32'd0);
        checkOutput("abortHi", hi, 32'd0);
        checkOutput("abortLo", lo, 32'd0);
        doneSeen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("abortNoDone", 32'(doneSeen), 32'd0);

        wrHi  = 1'b1;
        wdata = 32'h00001234;
        @(negedge clk);
        wrHi = 1'b0;
        checkOutput("mthiHi", hi, 32'h00001234);
        checkOutput("mthiLo", lo, 32'd0);

        wrHi  = 1'b1;
        wrLo  = 1'b1;
        wdata = 32'h000055AA;
        @(negedge clk);
        wrHi = 1'b0;
        wrLo = 1'b0;
        checkOutput("mthiBothHi", hi, 32'h000055AA);
        checkOutput("mtloBothLo", lo, 32'h000055AA);

        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
